// File: rtl/if_pkg.sv
// Shared defaults and the prefetch queue entry layout for the fetch front end.
package if_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned DEPTH_DEF    = 4;
  localparam int unsigned PC_STEP_DEF  = 1;
  localparam int unsigned RESET_PC_DEF = 0;
  localparam int unsigned CNT_W_DEF    = 4;

  // One queued fetch: the address after the fetched word, and the word itself.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] instruction;
  } if_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; head entry is presented combinationally.
module fetch_queue #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == OCC_W'(DEPTH));
  assign empty   = (count_q == '0);
  // A push into a full queue is legal only when the head leaves on the same edge.
  assign do_push = push && (!full || pop) && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; flush empties the queue outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction prefetch stage: fetch PC, prefetch queue, branch redirect and counter.
module if_prefetch_stage
  import if_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned PC_STEP  = PC_STEP_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              valid,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instruction,
  output logic [CNT_W-1:0]  branch_cnt
);

  localparam int unsigned          WIDTH = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0]    STEP  = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0]    PC0   = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic              q_full;
  logic              q_empty;
  logic              push;
  logic              pop;
  logic [WIDTH-1:0]  q_wdata;
  logic [WIDTH-1:0]  q_rdata;

  assign imem_addr   = fetch_pc_q;
  assign valid       = !q_empty;
  assign pop         = valid && !freeze && !branch_taken;
  // A redirect suppresses the fetch of the stale address in the same cycle.
  assign push        = (!q_full || pop) && !branch_taken;
  assign q_wdata     = {fetch_pc_q + STEP, imem_rdata};
  assign pc          = q_rdata[WIDTH-1 -: ADDR_W];
  assign instruction = q_rdata[DATA_W-1:0];
  assign branch_cnt  = branch_cnt_q;

  // Fetch PC and saturating branch counter next-state.
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    branch_cnt_d = branch_cnt_q;
    if (branch_taken) begin
      fetch_pc_d = branch_addr;
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + STEP;
    end
  end

  // Fetch PC and branch counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q   <= PC0;
      branch_cnt_q <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

  fetch_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fetch_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (branch_taken),
    .push  (push),
    .pop   (pop),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty)
  );

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Scoreboard bench for if_prefetch_stage: stimulus queues expected popped entries,
// a negedge monitor pops and compares every entry the stage hands downstream.
module tb_if_prefetch_stage;
  import if_pkg::*;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [3:0]  branch_cnt;

  int tests;
  int fails;

  if_entry_t exp_q[$];

  if_prefetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .valid        (valid),
    .pc           (pc),
    .instruction  (instruction),
    .branch_cnt   (branch_cnt)
  );

  // Instruction memory model.
  assign imem_rdata = imem_addr + 32'h100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic expect_entry(input logic [31:0] epc, input logic [31:0] einstr);
    if_entry_t e;
    e.pc          = epc;
    e.instruction = einstr;
    exp_q.push_back(e);
  endtask

  // Monitor: an entry is consumed on the next edge when valid && !freeze.
  always @(negedge clk) begin
    if (rst && valid && !freeze && !branch_taken) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got pc=0x%08h instr=0x%08h, expected no entry",
                 pc, instruction);
      end else begin
        if_entry_t e;
        e = exp_q.pop_front();
        if (pc !== e.pc || instruction !== e.instruction) begin
          fails++;
          $display("FAIL pop_entry: got pc=0x%08h instr=0x%08h, expected pc=0x%08h instr=0x%08h",
                   pc, instruction, e.pc, e.instruction);
        end
      end
    end
  end

  initial begin
    tests        = 0;
    fails        = 0;
    rst          = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = '0;

    // Reset state.
    #2;
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_cnt", {28'd0, branch_cnt}, 32'd0);
    check("reset_imem_addr", imem_addr, 32'd0);

    // Free-running stream after reset release.
    for (int i = 1; i <= 8; i++) expect_entry(i, 32'hFF + i);
    @(posedge clk); #1;
    rst = 1'b1;
    check("release_valid", {31'd0, valid}, 32'd0);
    @(posedge clk); #1;
    check("first_edge_valid", {31'd0, valid}, 32'd1);
    check("first_edge_pc", pc, 32'd1);
    repeat (8) @(posedge clk);
    #1;
    freeze = 1'b1;
    check("stream_drained", exp_q.size(), 32'd0);

    // Frozen from reset: queue fills, fetch address stalls, head holds.
    rst = 1'b0;
    #1;
    for (int i = 1; i <= 5; i++) expect_entry(i, 32'hFF + i);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("full_imem_addr", imem_addr, 32'd4);
    check("full_head_pc", pc, 32'd1);
    check("full_head_instr", instruction, 32'h100);
    repeat (2) @(posedge clk);
    #1;
    check("hold_imem_addr", imem_addr, 32'd4);
    check("hold_head_pc", pc, 32'd1);
    freeze = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    freeze = 1'b1;
    check("freeze_stream_drained", exp_q.size(), 32'd0);

    // Branch over a frozen full queue.
    @(posedge clk); #1;
    branch_taken = 1'b1;
    branch_addr  = 32'h40;
    @(posedge clk); #1;
    branch_taken = 1'b0;
    check("branch_flush_valid", {31'd0, valid}, 32'd0);
    check("branch_cnt_one", {28'd0, branch_cnt}, 32'd1);
    check("branch_imem_addr", imem_addr, 32'h40);
    @(posedge clk); #1;
    check("branch_refill_valid", {31'd0, valid}, 32'd1);
    check("branch_refill_pc", pc, 32'h41);
    check("branch_refill_instr", instruction, 32'h140);

    // Counter saturation over 18 consecutive branch cycles.
    branch_taken = 1'b1;
    repeat (13) @(posedge clk);
    #1;
    check("branch_cnt_14", {28'd0, branch_cnt}, 32'd14);
    repeat (5) @(posedge clk);
    #1;
    check("branch_cnt_sat", {28'd0, branch_cnt}, 32'd15);

    // Redirect to the top of the address space: pc wraps.
    branch_addr = 32'hFFFF_FFFF;
    expect_entry(32'h0, 32'h0000_00FF);
    expect_entry(32'h1, 32'h0000_0100);
    expect_entry(32'h2, 32'h0000_0101);
    @(posedge clk); #1;
    branch_taken = 1'b0;
    freeze       = 1'b0;
    check("wrap_cnt_hold", {28'd0, branch_cnt}, 32'd15);
    repeat (4) @(posedge clk);
    #1;
    freeze = 1'b1;
    check("wrap_drained", exp_q.size(), 32'd0);

    // Asynchronous reset mid-stream.
    expect_entry(32'h3, 32'h102);
    expect_entry(32'h4, 32'h103);
    expect_entry(32'h5, 32'h104);
    freeze = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, valid}, 32'd0);
    check("async_rst_cnt", {28'd0, branch_cnt}, 32'd0);
    check("async_rst_imem_addr", imem_addr, 32'd0);
    check("pre_rst_drained", exp_q.size(), 32'd0);
    expect_entry(32'h1, 32'h100);
    expect_entry(32'h2, 32'h101);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    freeze = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_prefetch_stage.md
IF_PREFETCH_STAGE -- requirements
Module: if_prefetch_stage

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the PC and instruction-address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the instruction width.
REQ-003 Parameter DEPTH, default 4, power of two >= 2, SHALL set the prefetch queue depth.
REQ-004 Parameter PC_STEP, default 1, SHALL set the word-addressed PC increment.
REQ-005 Parameter RESET_PC, default 0, SHALL set the first fetch address after reset.
REQ-006 Parameter CNT_W, default 4, SHALL set the branch-counter width.
REQ-007 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-008 rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-009 freeze  in  1  SHALL mean downstream stall: hold the current output entry.
REQ-010 branch_taken  in  1  SHALL mean redirect fetch to branch_addr.
REQ-011 branch_addr  in  ADDR_W  SHALL be the redirect target.
REQ-012 imem_addr  out  ADDR_W  SHALL be the current fetch address (combinational from fetch_pc).
REQ-013 imem_rdata  in  DATA_W  SHALL be the instruction at imem_addr, valid in the same cycle.
REQ-014 valid  out  1  SHALL mean pc/instruction hold a live fetched entry.
REQ-015 pc  out  ADDR_W  SHALL be the fetch address of the head entry plus PC_STEP.
REQ-016 instruction  out  DATA_W  SHALL be the head-entry instruction.
REQ-017 branch_cnt  out  CNT_W  SHALL count taken branches, saturating at all-ones.

Function
REQ-018 fetch_pc register SHALL drive imem_addr; push = !full || pop, and each push SHALL write {fetch_pc+PC_STEP, imem_rdata} to the queue tail and advance fetch_pc by PC_STEP.
REQ-019 pop SHALL equal valid && !freeze; it removes the head entry on the clock edge.
REQ-020 valid SHALL equal queue not empty; outputs SHALL come straight from the head entry (no extra register).
REQ-021 Latency: an address pushed at edge N SHALL appear on the outputs after edge N when the queue was empty.
REQ-022 Full queue with pop SHALL push and pop in the same cycle; occupancy unchanged.
REQ-023 Full queue without pop SHALL not push; fetch_pc holds.
REQ-024 Empty queue: pop is impossible (valid=0); push SHALL proceed.
REQ-025 branch_taken=1 SHALL flush all queue entries, suppress that cycle's push, and load fetch_pc <= branch_addr; next cycle valid=0.
REQ-026 branch_taken SHALL win over freeze, pop and push in the same cycle.
REQ-027 branch_cnt SHALL increment once per cycle with branch_taken=1 until all-ones, then hold.
REQ-028 fetch_pc, pc and queue pointers SHALL wrap modulo 2^ADDR_W / DEPTH without error.
REQ-029 Occupancy SHALL use a log2(DEPTH)+1-bit count so full and empty are unambiguous.

Reset
REQ-030 rst=0 SHALL immediately set fetch_pc=RESET_PC, queue empty (valid=0), branch_cnt=0, regardless of clk.
REQ-031 Reset mid-operation SHALL discard all entries; the first push after release SHALL fetch RESET_PC.
REQ-032 Queue data storage SHALL need no reset; pc/instruction are don't-care while valid=0.

Structure
REQ-033 Package if_pkg SHALL hold the parameter defaults and the entry type {pc, instruction}.
REQ-034 The queue SHALL be one sub-module, fetch_queue (synchronous FIFO with flush, push, pop, full, empty).
REQ-035 Fetch-PC, pop logic and branch counter SHALL live in if_prefetch_stage.

Verification (DEPTH=4, PC_STEP=1, RESET_PC=0, ADDR_W=DATA_W=32, imem_rdata = imem_addr + 0x100)
REQ-036 Release reset, freeze=0 -> valid=1 one edge later, with consecutive edges giving pc=1,2,3, ... and instruction=0x100,0x101,0x102, ...
REQ-037 freeze=1 for 6 cycles from reset -> after 4 edges queue full and imem_addr=4 holds; outputs hold pc=1/0x100; after release, entries stream pc=1..5 with no gap or duplicate.
REQ-038 branch_taken=1, branch_addr=0x40 with freeze=1 and full queue -> next cycle valid=0; following edge valid=1, pc=0x41, instruction=0x140; branch_cnt=1.
REQ-039 18 consecutive branch_taken cycles -> branch_cnt saturates at 15 and holds.
REQ-040 Assert rst=0 asynchronously mid-stream between edges -> valid=0 and branch_cnt=0 immediately; after release the first entry has pc=1.
REQ-041 branch_addr=0xFFFFFFFF -> entries show pc=0x00000000, then 0x00000001 (wrap), with instruction=0x000000FF, then 0x00000100.
